// File: rtl/dcache_mem_bridge.sv
// dcache_mem_bridge: L1 Dcache req/addrOK/dataOK protocol to a single-outstanding memory bus,
// with a posted write-through FIFO that reads are ordered against.
module dcache_mem_bridge #(
    parameter int OFFSET_WIDTH = 2,
    parameter int WBUF_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               dcache_mem_req,
    input  logic                               dcache_mem_wr,
    input  logic                               dcache_mem_uncached,
    input  logic [31:0]                        dcache_mem_addr,
    input  logic [31:0]                        dcache_mem_wdata,
    input  logic [3:0]                         dcache_mem_wstrb,
    output logic                               mem_dcache_addrOK,
    output logic                               mem_dcache_dataOK,
    output logic [32*(1<<OFFSET_WIDTH)-1:0]    mem_dcache_rdata,
    output logic                               bus_req,
    output logic                               bus_wr,
    output logic [31:0]                        bus_addr,
    output logic [7:0]                         bus_len,
    output logic [31:0]                        bus_wdata,
    output logic [3:0]                         bus_wstrb,
    input  logic                               bus_addr_ack,
    input  logic                               bus_rvalid,
    input  logic                               bus_rlast,
    input  logic [31:0]                        bus_rdata,
    input  logic                               bus_bvalid
);
    localparam int LINE_WORDS = 1 << OFFSET_WIDTH;
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam logic [31:0] WORD_MASK = ~32'h3;
    localparam logic [31:0] LINE_MASK = ~32'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {IDLE, W_ADDR, W_RESP, R_ADDR, R_DATA, R_DONE} state_t;
    state_t state, next_state;

    logic [31:0] wb_addr [WBUF_DEPTH];
    logic [31:0] wb_data [WBUF_DEPTH];
    logic [3:0]  wb_strb [WBUF_DEPTH];
    logic [PW-1:0] head, tail;
    logic [PW:0] count;
    logic [31:0] r_addr;
    logic r_unc;
    logic [OFFSET_WIDTH-1:0] beat;
    logic full, empty, push, pop, line_hit, go_read, last_beat;

    // full uses the pre-pop count, so a same-cycle pop never admits a push into a full FIFO
    assign full = count == (PW+1)'(WBUF_DEPTH);
    assign empty = count == '0;
    assign push = dcache_mem_req & dcache_mem_wr & ~full;
    assign pop = state == W_RESP && bus_bvalid;
    assign go_read = dcache_mem_req & ~dcache_mem_wr & (dcache_mem_uncached ? empty : ~line_hit);
    assign last_beat = bus_rvalid & (bus_rlast | r_unc | beat == OFFSET_WIDTH'(LINE_WORDS - 1));

    // slot i is live when its distance from head is below count; the head stays live until bvalid
    always_comb begin
        line_hit = 1'b0;
        for (int i = 0; i < WBUF_DEPTH; i++)
            if ({1'b0, PW'(i) - head} < count &&
                wb_addr[i][31:OFFSET_WIDTH+2] == dcache_mem_addr[31:OFFSET_WIDTH+2])
                line_hit = 1'b1;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = go_read ? R_ADDR : !empty ? W_ADDR : IDLE;
            W_ADDR:  next_state = bus_addr_ack ? W_RESP : W_ADDR;
            W_RESP:  next_state = bus_bvalid ? IDLE : W_RESP;
            R_ADDR:  next_state = bus_addr_ack ? R_DATA : R_ADDR;
            R_DATA:  next_state = last_beat ? R_DONE : R_DATA;
            R_DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus_req = state == W_ADDR || state == R_ADDR;
        bus_wr = state == W_ADDR;
        bus_addr = state == W_ADDR ? wb_addr[head] & WORD_MASK :
                   state == R_ADDR ? r_addr & (r_unc ? WORD_MASK : LINE_MASK) : '0;
        bus_len = state == R_ADDR && !r_unc ? 8'(LINE_WORDS - 1) : '0;
        bus_wdata = state == W_ADDR ? wb_data[head] : '0;
        bus_wstrb = state == W_ADDR ? wb_strb[head] : '0;
        mem_dcache_addrOK = push | (state == R_ADDR && bus_addr_ack);
        mem_dcache_dataOK = state == R_DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            r_addr <= '0;
            r_unc <= 1'b0;
            beat <= '0;
            mem_dcache_rdata <= '0;
            for (int i = 0; i < WBUF_DEPTH; i++) begin
                wb_addr[i] <= '0;
                wb_data[i] <= '0;
                wb_strb[i] <= '0;
            end
        end else begin
            if (push) begin
                wb_addr[tail] <= dcache_mem_addr;
                wb_data[tail] <= dcache_mem_wdata;
                wb_strb[tail] <= dcache_mem_wstrb;
                tail <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (state == IDLE && go_read) begin
                r_addr <= dcache_mem_addr;
                r_unc <= dcache_mem_uncached;
            end
            if (state == R_ADDR && bus_addr_ack) beat <= '0;
            if (state == R_DATA && bus_rvalid) begin
                mem_dcache_rdata[32*beat +: 32] <= bus_rdata;
                beat <= beat + 1'b1;
            end
        end
endmodule

// File: tb/tb_dcache_mem_bridge.sv
// tb_dcache_mem_bridge: scoreboard bench; expected bus transactions and refill lines are queued
// as stimulus is driven and popped when the bus handshakes or dataOK pulses.
module tb_dcache_mem_bridge;
    localparam int LW = 4;

    logic clk = 0, rst = 1;
    logic req = 0, wr = 0, unc = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [3:0] wstrb = 0;
    logic addrOK, dataOK;
    logic [32*LW-1:0] rdata;
    logic bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [7:0] bus_len;
    logic [3:0] bus_wstrb;
    logic bus_addr_ack, bus_rvalid, bus_rlast, bus_bvalid;
    logic ack_en = 0;

    typedef struct {
        logic wr;
        logic [31:0] addr;
        logic [7:0] len;
        logic [31:0] wdata;
        logic [3:0] wstrb;
    } txn_t;

    txn_t exp_bus[$];
    logic [32*LW-1:0] exp_rd[$];
    logic [31:0] beat_q[$];
    logic [32*LW-1:0] model_line = '0;
    logic [32*LW-1:0] m_exp;
    txn_t r_e;
    int r_len;
    logic r_wr;
    int n_checks = 0, n_fail = 0;
    int cyc = 0;
    int rd_limit = 1000;
    int beats_sent = 0;
    int last_beat_cyc = 0;
    bit resp_busy = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus_addr_ack = ack_en;

    dcache_mem_bridge #(.OFFSET_WIDTH(2), .WBUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .dcache_mem_req(req), .dcache_mem_wr(wr), .dcache_mem_uncached(unc),
        .dcache_mem_addr(addr), .dcache_mem_wdata(wdata), .dcache_mem_wstrb(wstrb),
        .mem_dcache_addrOK(addrOK), .mem_dcache_dataOK(dataOK), .mem_dcache_rdata(rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_len(bus_len),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_addr_ack(bus_addr_ack),
        .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rdata(bus_rdata),
        .bus_bvalid(bus_bvalid)
    );

    // Bus slave: checks each handshake against the expected order, bvalid two cycles on, read beats from beat_q
    initial begin
        bus_rvalid = 0; bus_rlast = 0; bus_rdata = '0; bus_bvalid = 0;
        forever begin
            @(negedge clk); #2;
            if (bus_req && ack_en) begin
                resp_busy = 1;
                r_len = int'(bus_len);
                r_wr = bus_wr;
                n_checks++;
                if (exp_bus.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_txn: unexpected wr=%0b addr=%h len=%0d", bus_wr, bus_addr, bus_len);
                end else begin
                    r_e = exp_bus.pop_front();
                    if (bus_wr !== r_e.wr || bus_addr !== r_e.addr || bus_len !== r_e.len ||
                        (r_e.wr && (bus_wdata !== r_e.wdata || bus_wstrb !== r_e.wstrb))) begin
                        n_fail++;
                        $display("FAIL bus_txn: got wr=%0b addr=%h len=%0d wdata=%h wstrb=%h, expected wr=%0b addr=%h len=%0d wdata=%h wstrb=%h",
                                 bus_wr, bus_addr, bus_len, bus_wdata, bus_wstrb, r_e.wr, r_e.addr, r_e.len, r_e.wdata, r_e.wstrb);
                    end
                end
                if (r_wr) begin
                    repeat (2) @(negedge clk);
                    #2 bus_bvalid = 1;
                    @(negedge clk); #2 bus_bvalid = 0;
                end else begin
                    beats_sent = 0;
                    for (int b = 0; b <= r_len && b < rd_limit; b++) begin
                        @(negedge clk); #2;
                        bus_rvalid = 1;
                        bus_rlast = (b == r_len);
                        if (beat_q.size() > 0) bus_rdata = beat_q.pop_front();
                        else bus_rdata = 32'hDEAD_BEEF;
                        if (b == r_len) last_beat_cyc = cyc;
                        beats_sent = b + 1;
                    end
                    @(negedge clk); #2 bus_rvalid = 0; bus_rlast = 0;
                end
                resp_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (dataOK === 1'b1) begin
            n_checks++;
            if (exp_rd.size() == 0) begin
                n_fail++;
                $display("FAIL rdata: unexpected dataOK, rdata=%h", rdata);
            end else begin
                m_exp = exp_rd.pop_front();
                if (rdata !== m_exp) begin
                    n_fail++;
                    $display("FAIL rdata: got %h, expected %h", rdata, m_exp);
                end
            end
        end
    end

    task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t t;
        t.wr = 1; t.addr = a & ~32'h3; t.len = 0; t.wdata = d; t.wstrb = s;
        exp_bus.push_back(t);
    endtask

    task automatic push_r(input logic [31:0] a, input logic [7:0] l);
        txn_t t;
        t.wr = 0; t.addr = a; t.len = l; t.wdata = 0; t.wstrb = 0;
        exp_bus.push_back(t);
    endtask

    // Entered and left at a negedge; lat counts cycles until addrOK
    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output int lat);
        req = 1; wr = 1; unc = 0; addr = a; wdata = d; wstrb = s;
        lat = 0;
        #1;
        while (!addrOK && lat < 300) begin @(negedge clk); #1; lat++; end
        @(negedge clk);
        req = 0; wr = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic u, input logic [32*LW-1:0] bl,
                           output bit got, output int done_cyc);
        int n;
        if (u) begin
            beat_q.push_back(bl[31:0]);
            model_line[31:0] = bl[31:0];
        end else begin
            for (int i = 0; i < LW; i++) beat_q.push_back(bl[32*i +: 32]);
            model_line = bl;
        end
        exp_rd.push_back(model_line);
        req = 1; wr = 0; unc = u; addr = a;
        n = 0;
        #1;
        while (!dataOK && n < 300) begin @(negedge clk); #1; n++; end
        got = dataOK;
        done_cyc = cyc;
        req = 0; unc = 0;
        @(negedge clk);
    endtask

    task automatic wait_drain(output bit ok);
        int n = 0;
        while ((exp_bus.size() != 0 || resp_busy) && n < 1000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        ok = n < 1000;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_checks++;
        if ({bus_req, bus_wr, addrOK, dataOK} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b, expected 0000", {bus_req, bus_wr, addrOK, dataOK});
        end
        n_checks++;
        if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h, expected 0", rdata); end
        n_checks++;
        if ({bus_addr, bus_len, bus_wdata, bus_wstrb} !== '0) begin
            n_fail++; $display("FAIL reset_bus: got addr=%h len=%h wdata=%h wstrb=%h, expected 0", bus_addr, bus_len, bus_wdata, bus_wstrb);
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_write_fifo_full;
        int lat;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            push_w(32'h1000 * (i + 1), 32'hA000_0000 + i, 4'hF);
            do_store(32'h1000 * (i + 1), 32'hA000_0000 + i, 4'hF, lat);
            n_checks++;
            if (lat !== 0) begin n_fail++; $display("FAIL store_accept%0d: latency %0d, expected 0", i, lat); end
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bus_req !== 1'b1 || bus_addr !== 32'h1000 || bus_wdata !== 32'hA000_0000) begin
                n_fail++; $display("FAIL stall_stable: req=%b addr=%h wdata=%h, expected 1 00001000 a0000000", bus_req, bus_addr, bus_wdata);
            end
            @(negedge clk);
        end
        push_w(32'h5000, 32'hA000_0004, 4'h3);
        req = 1; wr = 1; addr = 32'h5000; wdata = 32'hA000_0004; wstrb = 4'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (addrOK !== 1'b0) begin n_fail++; $display("FAIL full_block: addrOK=%b, expected 0", addrOK); end
            @(negedge clk);
        end
        ack_en = 1;
        lat = 0;
        #1;
        while (!addrOK && lat < 300) begin @(negedge clk); #1; lat++; end
        n_checks++;
        if (lat >= 300) begin n_fail++; $display("FAIL full_release: addrOK=%b after %0d cycles, expected 1", addrOK, lat); end
        @(negedge clk);
        req = 0; wr = 0;
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain1: %0d bus txns left, expected 0", exp_bus.size()); end
    endtask

    task automatic test_cached_read;
        bit got, ok;
        int dc;
        push_r(32'h100, 8'd3);
        do_read(32'h100, 0, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, got, dc);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL read_done: dataOK=%b, expected 1", got); end
        n_checks++;
        if (dc - last_beat_cyc !== 1) begin n_fail++; $display("FAIL read_latency: %0d cycles after last beat, expected 1", dc - last_beat_cyc); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain2: %0d bus txns left, expected 0", exp_bus.size()); end
    endtask

    task automatic test_line_hazard;
        bit got, ok;
        int dc, lat;
        push_w(32'h104, 32'h5555_0104, 4'b0101);
        push_r(32'h100, 8'd3);
        do_store(32'h104, 32'h5555_0104, 4'b0101, lat);
        do_read(32'h10C, 0, {32'h1300_0000, 32'h1200_0000, 32'h1100_0000, 32'h1000_0000}, got, dc);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL hazard_read: dataOK=%b, expected 1", got); end
        wait_drain(ok);
        push_r(32'h200, 8'd3);
        push_w(32'h104, 32'h6666_0104, 4'b1010);
        do_store(32'h104, 32'h6666_0104, 4'b1010, lat);
        do_read(32'h200, 0, {32'h2300_0000, 32'h2200_0000, 32'h2100_0000, 32'h2000_0000}, got, dc);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL bypass_read: dataOK=%b, expected 1", got); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain3: %0d bus txns left, expected 0", exp_bus.size()); end
    endtask

    task automatic test_uncached_read;
        bit got, ok;
        int dc, lat;
        ack_en = 0;
        push_w(32'h300, 32'h0000_0300, 4'hF);
        push_w(32'h400, 32'h0000_0400, 4'hF);
        push_r(32'h1F00_0004, 8'd0);
        do_store(32'h300, 32'h0000_0300, 4'hF, lat);
        do_store(32'h400, 32'h0000_0400, 4'hF, lat);
        ack_en = 1;
        do_read(32'h1F00_0004, 1, {96'h0, 32'hC0DE_F00D}, got, dc);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL uncached_read: dataOK=%b, expected 1", got); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain4: %0d bus txns left, expected 0", exp_bus.size()); end
    endtask

    task automatic test_wrap;
        int lat, n;
        bit ok;
        ack_en = 0;
        for (int i = 0; i < 6; i++) push_w(32'h600 + 32'h100 * i, 32'hB000_0000 + i, 4'hF);
        for (int i = 0; i < 3; i++) do_store(32'h600 + 32'h100 * i, 32'hB000_0000 + i, 4'hF, lat);
        ack_en = 1;
        n = 0;
        do begin @(negedge clk); #3; n++; end while (!bus_bvalid && n < 50);
        n_checks++;
        if (n >= 50) begin n_fail++; $display("FAIL wrap_bvalid: bvalid=%b after %0d cycles, expected 1", bus_bvalid, n); end
        ack_en = 0;
        req = 1; wr = 1; addr = 32'h900; wdata = 32'hB000_0003; wstrb = 4'hF;
        #1;
        n_checks++;
        if (addrOK !== 1'b1) begin n_fail++; $display("FAIL push_on_pop: addrOK=%b, expected 1", addrOK); end
        @(negedge clk);
        req = 0; wr = 0;
        do_store(32'hA00, 32'hB000_0004, 4'hF, lat);
        n_checks++;
        if (lat !== 0) begin n_fail++; $display("FAIL wrap_fill: latency %0d, expected 0", lat); end
        req = 1; wr = 1; addr = 32'hB00; wdata = 32'hB000_0005; wstrb = 4'hF;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (addrOK !== 1'b0) begin n_fail++; $display("FAIL wrap_full: addrOK=%b, expected 0", addrOK); end
            @(negedge clk);
        end
        ack_en = 1;
        lat = 0;
        #1;
        while (!addrOK && lat < 300) begin @(negedge clk); #1; lat++; end
        @(negedge clk);
        req = 0; wr = 0;
        wait_drain(ok);
        n_checks++;
        if (!ok || lat >= 300) begin n_fail++; $display("FAIL drain5: %0d bus txns left, wait %0d, expected 0", exp_bus.size(), lat); end
    endtask

    task automatic test_reset_mid_read;
        bit got, ok;
        int dc, n;
        push_r(32'h500, 8'd3);
        beat_q.push_back(32'h5000_0000);
        beat_q.push_back(32'h5100_0000);
        rd_limit = 2;
        beats_sent = 0;
        req = 1; wr = 0; unc = 0; addr = 32'h500;
        n = 0;
        do begin @(negedge clk); #3; n++; end while (beats_sent < 2 && n < 100);
        n_checks++;
        if (n >= 100) begin n_fail++; $display("FAIL mid_read_beats: %0d beats, expected 2", beats_sent); end
        @(negedge clk); #3;
        rst = 1;
        #1;
        n_checks++;
        if ({bus_req, bus_wr, addrOK, dataOK} !== 4'b0 || rdata !== '0) begin
            n_fail++; $display("FAIL async_reset: ctl=%b rdata=%h, expected 0000 0", {bus_req, bus_wr, addrOK, dataOK}, rdata);
        end
        n_checks++;
        if ({bus_addr, bus_len, bus_wdata, bus_wstrb} !== '0) begin
            n_fail++; $display("FAIL async_reset_bus: addr=%h len=%h, expected 0", bus_addr, bus_len);
        end
        req = 0;
        @(negedge clk);
        rst = 0;
        rd_limit = 1000;
        model_line = '0;
        @(negedge clk);
        push_r(32'h740, 8'd3);
        do_read(32'h748, 0, {32'h7300_0000, 32'h7200_0000, 32'h7100_0000, 32'h7000_0000}, got, dc);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL post_reset_read: dataOK=%b, expected 1", got); end
        wait_drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL drain6: %0d bus txns left, expected 0", exp_bus.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_fifo_full();
        test_cached_read();
        test_line_hazard();
        test_uncached_read();
        test_wrap();
        test_reset_mid_read();
        n_checks++;
        if (exp_bus.size() != 0 || exp_rd.size() != 0) begin
            n_fail++; $display("FAIL leftover: bus=%0d reads=%0d, expected 0 0", exp_bus.size(), exp_rd.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
